// File: rtl/escalonador_drone.sv
//==============================================================================
// escalonador_drone: control FSM for the drone simulator datapath.
// Optional feature macro: DRONE_PAUSA_EN (controle=11 freezes the step wait).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module escalonador_drone #(
  parameter int PERIODO  = 2000,
  parameter int VERT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] controle,
  input  logic [3:0] posicao_vertical,
  input  logic       colisao,
  input  logic       fim_percurso,
  output logic       zera_posicao,
  output logic       carrega_obstaculos,
  output logic       avanca,
  output logic       sobe,
  output logic       desce,
  output logic       venceu,
  output logic       perdeu,
  output logic [3:0] db_estado
);

  localparam int            C_CW       = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  localparam logic [C_CW-1:0] C_ULTIMO = C_CW'(PERIODO - 1);
  localparam logic [3:0]    C_VERT_MAX = 4'(VERT_MAX);

  typedef enum logic [3:0] {
    INICIAL  = 4'b0000,
    PREPARA  = 4'b0001,
    ESPERA   = 4'b0010,
    MOVE     = 4'b0011,
    VERIFICA = 4'b0100,
    VENCEU   = 4'b1010,
    PERDEU   = 4'b1110
  } estado_t;

  estado_t         r_estado;
  estado_t         w_prox;
  logic [C_CW-1:0] r_cont;
  logic            r_prepara;
  logic            r_avanca;
  logic            r_venceu;
  logic            r_perdeu;
  logic            w_pausa;
  logic            w_fim_espera;

`ifdef DRONE_PAUSA_EN
  assign w_pausa = (controle == 2'b11);
`else
  assign w_pausa = 1'b0;
`endif

  assign w_fim_espera = (r_cont == C_ULTIMO);

  always_comb begin
    w_prox = INICIAL;
    case (r_estado)
      INICIAL:  w_prox = iniciar ? PREPARA : INICIAL;
      PREPARA:  w_prox = ESPERA;
      ESPERA:   w_prox = (!w_pausa && w_fim_espera) ? MOVE : ESPERA;
      MOVE:     w_prox = VERIFICA;
      VERIFICA: begin
        if (colisao)           w_prox = PERDEU;
        else if (fim_percurso) w_prox = VENCEU;
        else                   w_prox = ESPERA;
      end
      VENCEU:   w_prox = iniciar ? PREPARA : VENCEU;
      PERDEU:   w_prox = iniciar ? PREPARA : PERDEU;
      default:  w_prox = INICIAL;
    endcase
  end

  // Moore outputs are registered from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado  <= INICIAL;
      r_cont    <= '0;
      r_prepara <= 1'b0;
      r_avanca  <= 1'b0;
      r_venceu  <= 1'b0;
      r_perdeu  <= 1'b0;
    end else begin
      r_estado <= w_prox;
      if (r_estado == ESPERA) begin
        if (!w_pausa) r_cont <= w_fim_espera ? '0 : r_cont + C_CW'(1);
      end else begin
        r_cont <= '0;
      end
      r_prepara <= (w_prox == PREPARA);
      r_avanca  <= (w_prox == MOVE);
      r_venceu  <= (w_prox == VENCEU);
      r_perdeu  <= (w_prox == PERDEU);
    end
  end

  // Vertical commands use the live pilot input during MOVE, saturated at the edges.
  assign sobe  = (r_estado == MOVE) && (controle == 2'b01) && (posicao_vertical != C_VERT_MAX);
  assign desce = (r_estado == MOVE) && (controle == 2'b10) && (posicao_vertical != 4'd0);

  assign zera_posicao       = r_prepara;
  assign carrega_obstaculos = r_prepara;
  assign avanca             = r_avanca;
  assign venceu             = r_venceu;
  assign perdeu             = r_perdeu;
  assign db_estado          = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_escalonador_drone.sv
//==============================================================================
// tb_escalonador_drone: self-checking bench for escalonador_drone (PERIODO=4).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_escalonador_drone;

  localparam int P    = 4;
  localparam int VMAX = 15;
`ifdef DRONE_PAUSA_EN
  localparam int ATRASO_PAUSA = 20;
`else
  localparam int ATRASO_PAUSA = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [1:0] controle;
  logic [3:0] posicao_vertical;
  logic       colisao;
  logic       fim_percurso;
  logic       zera_posicao, carrega_obstaculos, avanca, sobe, desce, venceu, perdeu;
  logic [3:0] db_estado;
  logic [10:0] saida;

  int n_checks = 0;
  int n_pass   = 0;

  escalonador_drone #(.PERIODO(P), .VERT_MAX(VMAX)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .controle(controle),
    .posicao_vertical(posicao_vertical), .colisao(colisao), .fim_percurso(fim_percurso),
    .zera_posicao(zera_posicao), .carrega_obstaculos(carrega_obstaculos),
    .avanca(avanca), .sobe(sobe), .desce(desce), .venceu(venceu), .perdeu(perdeu),
    .db_estado(db_estado)
  );

  assign saida = {db_estado, zera_posicao, carrega_obstaculos, avanca, sobe, desce, venceu, perdeu};

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic set_idle_inputs();
    iniciar = 1'b0; controle = 2'b00; posicao_vertical = 4'd7;
    colisao = 1'b0; fim_percurso = 1'b0;
  endtask

  task automatic do_reset();
    set_idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Returns during the PREPARA cycle, just after its rising edge.
  task automatic start_game();
    iniciar = 1'b1;
    next_cycle();
    iniciar = 1'b0;
  endtask

  // Counts cycles (current one is 0) until avanca is seen; ends at that cycle's negedge.
  task automatic wait_avanca(input int limit, output int ciclos, output bit ok);
    ok = 1'b0;
    ciclos = 0;
    for (int i = 0; i < limit; i++) begin
      sample();
      if (avanca) begin
        ok = 1'b1;
        return;
      end
      next_cycle();
      ciclos++;
    end
  endtask

  task automatic test_reset();
    int n_av;
    int bad_db;
    sample();
    n_checks++;
    if (saida !== 11'd0) $display("FAIL reset_outputs: got %b expected %b", saida, 11'd0);
    else n_pass++;
    do_reset();
    start_game();
    next_cycle();
    next_cycle();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (saida !== 11'd0) $display("FAIL reset_async_mid_espera: got %b expected %b", saida, 11'd0);
    else n_pass++;
    @(posedge clock);
    #1 reset = 1'b0;
    n_av = 0;
    bad_db = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (avanca) n_av++;
      if (db_estado !== 4'b0000) bad_db++;
      next_cycle();
    end
    n_checks++;
    if (n_av != 0) $display("FAIL reset_no_avanca: got %0d pulses expected 0", n_av);
    else n_pass++;
    n_checks++;
    if (bad_db != 0) $display("FAIL reset_stays_inicial: got %0d bad cycles expected 0", bad_db);
    else n_pass++;
  endtask

  task automatic test_start_timing();
    int n_zera, n_carrega, n_av, n_vert, bad_gap, primeiro, anterior, ciclo_zera;
    do_reset();
    n_zera = 0; n_carrega = 0; n_av = 0; n_vert = 0; bad_gap = 0;
    primeiro = -1; anterior = -1; ciclo_zera = -1;
    for (int c = 0; c < 40; c++) begin
      iniciar = (c < 5);
      sample();
      if (zera_posicao) begin n_zera++; ciclo_zera = c; end
      if (carrega_obstaculos) n_carrega++;
      if (sobe || desce) n_vert++;
      if (avanca) begin
        n_av++;
        if (primeiro < 0) primeiro = c;
        else if (c - anterior != P + 2) bad_gap++;
        anterior = c;
      end
      next_cycle();
    end
    iniciar = 1'b0;
    n_checks++;
    if (n_zera != 1 || ciclo_zera != 1)
      $display("FAIL start_zera: got %0d pulses at %0d expected 1 at 1", n_zera, ciclo_zera);
    else n_pass++;
    n_checks++;
    if (n_carrega != 1) $display("FAIL start_carrega: got %0d expected 1", n_carrega);
    else n_pass++;
    n_checks++;
    if (primeiro != P + 2) $display("FAIL start_first_avanca: got cycle %0d expected %0d", primeiro, P + 2);
    else n_pass++;
    n_checks++;
    if (n_av != 6 || bad_gap != 0)
      $display("FAIL start_step_period: got %0d pulses %0d bad gaps expected 6 and 0", n_av, bad_gap);
    else n_pass++;
    n_checks++;
    if (n_vert != 0) $display("FAIL start_no_vertical: got %0d expected 0", n_vert);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int n;
    bit ok;
    logic [1:0] ctl_tab [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
    logic [3:0] pos_tab [5] = '{4'd15, 4'd0, 4'd14, 4'd1, 4'd7};
    logic [2:0] exp_tab [5] = '{3'b100, 3'b100, 3'b110, 3'b101, 3'b100};
    do_reset();
    start_game();
    for (int i = 0; i < 5; i++) begin
      controle = ctl_tab[i];
      posicao_vertical = pos_tab[i];
      wait_avanca(20, n, ok);
      n_checks++;
      if (!ok || n != P + 1)
        $display("FAIL sat_move_timing_%0d: got ok=%0d cycles=%0d expected ok=1 cycles=%0d", i, ok, n, P + 1);
      else n_pass++;
      n_checks++;
      if ({avanca, sobe, desce} !== exp_tab[i])
        $display("FAIL sat_pulses_%0d: got %b expected %b", i, {avanca, sobe, desce}, exp_tab[i]);
      else n_pass++;
      next_cycle();
    end
    set_idle_inputs();
  endtask

  task automatic test_collision();
    int n;
    bit ok;
    do_reset();
    start_game();
    wait_avanca(20, n, ok);
    n_checks++;
    if (!ok) $display("FAIL coll_reach_move: got timeout expected avanca");
    else n_pass++;
    next_cycle();
    colisao = 1'b1; fim_percurso = 1'b1;
    sample();
    n_checks++;
    if (db_estado !== 4'b0100) $display("FAIL coll_verifica: got %b expected 0100", db_estado);
    else n_pass++;
    next_cycle();
    colisao = 1'b0; fim_percurso = 1'b0;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_checks++;
      if (saida !== {4'b1110, 7'b0000001})
        $display("FAIL coll_perdeu_%0d: got %b expected %b", c, saida, {4'b1110, 7'b0000001});
      else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_win_restart();
    int n;
    bit ok;
    do_reset();
    start_game();
    wait_avanca(20, n, ok);
    next_cycle();
    fim_percurso = 1'b1;
    sample();
    next_cycle();
    fim_percurso = 1'b0;
    colisao = 1'b1;
    for (int c = 0; c < 3; c++) begin
      sample();
      n_checks++;
      if (saida !== {4'b1010, 7'b0000010})
        $display("FAIL win_venceu_%0d: got %b expected %b", c, saida, {4'b1010, 7'b0000010});
      else n_pass++;
      next_cycle();
    end
    colisao = 1'b0;
    iniciar = 1'b1;
    sample();
    next_cycle();
    iniciar = 1'b0;
    sample();
    n_checks++;
    if (saida !== {4'b0001, 7'b1100000})
      $display("FAIL win_restart_prepara: got %b expected %b", saida, {4'b0001, 7'b1100000});
    else n_pass++;
    next_cycle();
    wait_avanca(20, n, ok);
    n_checks++;
    if (!ok || n != P)
      $display("FAIL win_restart_step: got ok=%0d cycles=%0d expected ok=1 cycles=%0d", ok, n, P);
    else n_pass++;
  endtask

  task automatic test_pause();
    int primeiro, segundo, n_vert;
    do_reset();
    start_game();
    next_cycle();
    primeiro = -1; segundo = -1; n_vert = 0;
    for (int k = 0; k < 60; k++) begin
      controle = (k < 20) ? 2'b11 : 2'b00;
      sample();
      if (sobe || desce) n_vert++;
      if (avanca) begin
        if (primeiro < 0) primeiro = k;
        else if (segundo < 0) segundo = k;
      end
      next_cycle();
    end
    controle = 2'b00;
    n_checks++;
    if (primeiro != P + ATRASO_PAUSA)
      $display("FAIL pause_first_avanca: got %0d expected %0d", primeiro, P + ATRASO_PAUSA);
    else n_pass++;
    n_checks++;
    if (segundo - primeiro != P + 2)
      $display("FAIL pause_next_period: got %0d expected %0d", segundo - primeiro, P + 2);
    else n_pass++;
    n_checks++;
    if (n_vert != 0) $display("FAIL pause_no_vertical: got %0d expected 0", n_vert);
    else n_pass++;
  endtask

  // Game-level reference: mode (0 idle, 1 playing, 2 won, 3 lost) and cycles since PREPARA.
  task automatic test_random();
    int modo, t, k, r;
    logic [10:0] esperado;
    do_reset();
    modo = 0;
    t = 0;
    for (int c = 0; c < 400; c++) begin
      iniciar = ($urandom_range(0, 7) == 0);
      controle = 2'($urandom_range(0, 3));
`ifdef DRONE_PAUSA_EN
      if (controle == 2'b11) controle = 2'b00;
`endif
      r = $urandom_range(0, 3);
      posicao_vertical = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
      colisao = ($urandom_range(0, 5) == 0);
      fim_percurso = ($urandom_range(0, 4) == 0);
      sample();
      esperado = '0;
      k = (t > 0) ? (t - 1) % (P + 2) : 0;
      case (modo)
        1: begin
          if (t == 0) esperado = {4'd1, 7'b1100000};
          else if (k < P) esperado = {4'd2, 7'b0};
          else if (k == P) begin
            esperado = {4'd3, 7'b0010000};
            esperado[3] = (controle == 2'b01) && (int'(posicao_vertical) != VMAX);
            esperado[2] = (controle == 2'b10) && (posicao_vertical != 4'd0);
          end else esperado = {4'd4, 7'b0};
        end
        2: esperado = {4'd10, 7'b0000010};
        3: esperado = {4'd14, 7'b0000001};
        default: esperado = '0;
      endcase
      n_checks++;
      if (saida !== esperado)
        $display("FAIL random_cycle_%0d: got %b expected %b", c, saida, esperado);
      else n_pass++;
      case (modo)
        0, 2, 3: if (iniciar) begin modo = 1; t = 0; end
        default: begin
          if (t > 0 && k == P + 1 && colisao) modo = 3;
          else if (t > 0 && k == P + 1 && fim_percurso) modo = 2;
          else t++;
        end
      endcase
      next_cycle();
    end
    set_idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    set_idle_inputs();
    test_reset();
    test_start_timing();
    test_saturation();
    test_collision();
    test_win_restart();
    test_pause();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
